// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-at-a-time request/response controller for the 8-bit adder/subtractor/divider.
// Optional divider watchdog enabled by defining ALU_SEQ_DIV_TIMEOUT_EN (limit = DIV_TIMEOUT cycles).
module alu_op_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIV_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [1:0]       au_op,
    input  logic [WIDTH-1:0] au_result,
    input  logic             au_flag,
    output logic             div_start,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_flag,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT_DIV, ST_RESP} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_DIV = 2'b10, OP_ILL = 2'b11} op_t;

    if (WIDTH < 1) begin : g_bad_width
        $error("alu_op_sequencer: WIDTH must be at least 1");
    end
    if (DIV_TIMEOUT < 1) begin : g_bad_timeout
        $error("alu_op_sequencer: DIV_TIMEOUT must be at least 1");
    end

    state_t r_state;

`ifdef ALU_SEQ_DIV_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    logic [CNT_W-1:0] r_div_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            au_a       <= '0;
            au_b       <= '0;
            au_op      <= OP_ADD;
            div_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_rem    <= '0;
            rsp_flag   <= 1'b0;
            rsp_err    <= 1'b0;
`ifdef ALU_SEQ_DIV_TIMEOUT_EN
            r_div_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        au_a      <= req_a;
                        au_b      <= req_b;
                        au_op     <= req_op;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        // start pulse is registered here so it is high for exactly the EXEC cycle
                        div_start <= (req_op == OP_DIV) && (req_b != '0);
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    div_start <= 1'b0;
                    case (au_op)
                        OP_ADD, OP_SUB: begin
                            rsp_result <= au_result;
                            rsp_flag   <= au_flag;
                            rsp_rem    <= '0;
                            rsp_err    <= 1'b0;
                            rsp_valid  <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                        OP_DIV: begin
                            if (au_b == '0) begin
                                rsp_result <= '1;
                                rsp_rem    <= au_a;
                                rsp_flag   <= 1'b0;
                                rsp_err    <= 1'b1;
                                rsp_valid  <= 1'b1;
                                r_state    <= ST_RESP;
                            end else begin
`ifdef ALU_SEQ_DIV_TIMEOUT_EN
                                r_div_cnt <= '0;
`endif
                                r_state   <= ST_WAIT_DIV;
                            end
                        end
                        default: begin
                            rsp_result <= '0;
                            rsp_rem    <= '0;
                            rsp_flag   <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    endcase
                end
                ST_WAIT_DIV: begin
                    div_start <= 1'b0;
                    if (div_done) begin
                        rsp_result <= div_quot;
                        rsp_rem    <= div_rem;
                        rsp_flag   <= 1'b0;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        r_state    <= ST_RESP;
                    end
`ifdef ALU_SEQ_DIV_TIMEOUT_EN
                    // done has priority over the watchdog when both land on the same edge
                    else if (r_div_cnt == CNT_LAST) begin
                        rsp_result <= '0;
                        rsp_rem    <= '0;
                        rsp_flag   <= 1'b0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: AU and divider models drive the datapath side,
// responses are compared with an arithmetic reference computed from the request.
module tb_alu_op_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic [W-1:0] au_a, au_b;
    logic [1:0]   au_op;
    logic [W-1:0] au_result;
    logic         au_flag;
    logic         div_start, div_done;
    logic [W-1:0] div_quot, div_rem;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result, rsp_rem;
    logic         rsp_flag, rsp_err, busy;

    alu_op_sequencer #(.WIDTH(W), .DIV_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .au_a(au_a), .au_b(au_b), .au_op(au_op),
        .au_result(au_result), .au_flag(au_flag),
        .div_start(div_start), .div_done(div_done),
        .div_quot(div_quot), .div_rem(div_rem),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_rem(rsp_rem),
        .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Combinational adder/subtractor
    logic [W:0] w_sum, w_diff;
    assign w_sum     = {1'b0, au_a} + {1'b0, au_b};
    assign w_diff    = {1'b0, au_a} - {1'b0, au_b};
    assign au_result = (au_op == 2'b01) ? w_diff[W-1:0] : w_sum[W-1:0];
    assign au_flag   = (au_op == 2'b01) ? w_diff[W] : w_sum[W];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Divider model: done pulses div_delay cycles after the start pulse (0 = never)
    int div_delay   = 5;
    int div_cnt     = 0;
    int start_seen  = 0;
    bit inject_done = 1'b0;

    initial begin
        div_done = 1'b0;
        div_quot = '0;
        div_rem  = '0;
        forever begin
            @(posedge clk); #1;
            div_done = 1'b0;
            if (div_start === 1'b1) start_seen++;
            if (inject_done) begin
                div_done    = 1'b1;
                div_quot    = 8'h5A;
                div_rem     = 8'hA5;
                inject_done = 1'b0;
            end else if (!rst) begin
                div_cnt = 0;
            end else if (div_start === 1'b1) begin
                div_cnt = div_delay;
            end else if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    div_done = 1'b1;
                    div_quot = au_a / au_b;
                    div_rem  = au_a % au_b;
                end
            end
        end
    end

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] rem;
        logic       flag;
        logic       err;
    } rsp_t;

    function automatic rsp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int   ia = int'(a);
        int   ib = int'(b);
        rsp_t r  = '0;
        case (op)
            2'd0: begin r.res = 8'((ia + ib) % 256); r.flag = (ia + ib) > 255; end
            2'd1: begin r.res = 8'((ia - ib + 256) % 256); r.flag = ia < ib; end
            2'd2: begin
                if (ib == 0) begin r.res = 8'hFF; r.rem = a; r.err = 1'b1; end
                else begin r.res = 8'(ia / ib); r.rem = 8'(ia % ib); end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int dly, input int bp);
        rsp_t e;
        int   lat;
        int   s0;
        int   exp_lat;
        bit   real_div;
        bit   busy_ok;
        e        = model(op, a, b);
        real_div = (op == 2'd2) && (b != 8'd0);
        exp_lat  = real_div ? dly + 1 : 1;
        if (real_div && dly == 0) begin
            exp_lat = TO + 1;
            e       = '0;
            e.err   = 1'b1;
        end
        div_delay = dly;
        for (int k = 0; k < 50 && !req_ready; k++) begin @(posedge clk); #1; end
        check("req_ready_idle", req_ready, 1);
        s0        = start_seen;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 2'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        rsp_ready = 1'($urandom_range(0, 1));
        check("accept_req_ready", req_ready, 0);
        check("accept_au_op", au_op, op);
        check("accept_au_ab", {au_a, au_b}, {a, b});
        lat     = 0;
        busy_ok = 1'b1;
        while (!rsp_valid && lat < 200) begin
            if (busy !== 1'b1 || req_ready !== 1'b0) busy_ok = 1'b0;
            if (lat > 0) rsp_ready = 1'($urandom_range(0, 1));
            if (lat == exp_lat - 1) rsp_ready = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rsp_ready = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        check("latency", lat, exp_lat);
        check("busy_during_op", busy_ok, 1);
        check("rsp_fields", {rsp_result, rsp_rem, rsp_flag, rsp_err}, e);
        check("div_start_cycles", start_seen - s0, real_div ? 1 : 0);
        check("au_hold", {au_op, au_a, au_b}, {op, a, b});
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            req_a     = 8'($urandom);
            @(posedge clk); #1;
            check("bp_stable", {rsp_valid, req_ready, busy, rsp_result, rsp_rem, rsp_flag, rsp_err},
                  {3'b101, e});
        end
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        check("handshake_idle", {rsp_valid, req_ready, busy}, 3'b010);
        check("no_accept_on_handshake", {au_op, au_a, au_b}, {op, a, b});
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {req_ready, busy, rsp_valid, div_start}, 4'b1000);
        check("reset_data", {au_op, au_a, au_b, rsp_result, rsp_rem, rsp_flag, rsp_err}, '0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_txn(2'd0, 8'd200, 8'd100, 1, 0);
        run_txn(2'd1, 8'd5, 8'd9, 1, 0);
        run_txn(2'd2, 8'd100, 8'd7, 9, 0);
        run_txn(2'd2, 8'd50, 8'd0, 9, 0);
        run_txn(2'd3, 8'h12, 8'h34, 1, 0);
        run_txn(2'd0, 8'h10, 8'h20, 1, 5);
        run_txn(2'd2, 8'd255, 8'd1, 1, 2);
`ifdef ALU_SEQ_DIV_TIMEOUT_EN
        run_txn(2'd2, 8'd77, 8'd5, 0, 0);
        run_txn(2'd2, 8'd77, 8'd5, TO, 0);
`endif
        repeat (40) begin
            logic [1:0] op;
            logic [7:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_txn(op, a, b, $urandom_range(1, 12), $urandom_range(0, 3));
        end

        // Reset while waiting for the divider, then a stray done
        div_delay = 20;
        req_valid = 1'b1; req_op = 2'd2; req_a = 8'd100; req_b = 8'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("wait_div_busy", {busy, rsp_valid}, 2'b10);
        #2 rst = 1'b0;
        #1;
        check("async_reset_ctrl", {req_ready, busy, rsp_valid, div_start}, 4'b1000);
        check("async_reset_data", {au_op, au_a, au_b, rsp_result, rsp_rem, rsp_flag, rsp_err}, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        inject_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle", {rsp_valid, busy, req_ready, rsp_result}, {3'b001, 8'h00});
        end
        run_txn(2'd1, 8'd0, 8'd1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
